// File: rtl/ss_mac_pkg.sv
// Shared definitions for the stochastic-symbol MAC: FSM states, default
// widths and the symbol saturation helper.
package ss_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ss_state_e;

    localparam int SS_DEF_N_CH   = 8;
    localparam int SS_DEF_IN_W   = 9;
    localparam int SS_DEF_RAND_W = 8;
    localparam int SS_DEF_SS_W   = 2;
    localparam int SS_DEF_LEN_W  = 10;
    localparam int SS_DEF_ACC_W  = 16;

    // Largest value a symbol of ss_w bits may take.
    function automatic int ss_sym_max(input int ss_w);
        return (1 << ss_w) - 1;
    endfunction

endpackage

// File: rtl/ss_mac_seq_if.sv
// Handshake, data and result bundle for ss_mac_seq. The master side issues
// runs and supplies magnitudes/random numbers; the slave side is the MAC.
interface ss_mac_seq_if #(
    parameter int N_CH   = 8,
    parameter int IN_W   = 9,
    parameter int RAND_W = 8,
    parameter int SS_W   = 2,
    parameter int LEN_W  = 10,
    parameter int ACC_W  = 16
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [N_CH*IN_W-1:0]     x_input;
    logic [N_CH*RAND_W-1:0]   x_randnum;
    logic                     busy;
    logic                     done;
    logic [ACC_W-1:0]         z_output;
    logic                     ovf;

    modport master (
        output start, len, mode, sel, x_input, x_randnum,
        input  busy, done, z_output, ovf
    );

    modport slave (
        input  start, len, mode, sel, x_input, x_randnum,
        output busy, done, z_output, ovf
    );

endinterface

// File: rtl/ss_symbol_gen.sv
// Combinational magnitude-to-symbol converter for one channel: the upper
// magnitude bits plus a stochastic round-up bit, saturated to the symbol range.
module ss_symbol_gen
    import ss_mac_pkg::*;
#(
    parameter int IN_W   = 9,
    parameter int RAND_W = 8,
    parameter int SS_W   = 2
) (
    input  logic [IN_W-1:0]   x,
    input  logic [RAND_W-1:0] rnd,
    output logic [SS_W-1:0]   s
);
    localparam int HI_W  = IN_W - RAND_W;
    // Wide enough that neither the upper bits nor the carry are lost before saturation.
    localparam int SUM_W = ((HI_W > SS_W) ? HI_W : SS_W) + 1;
    localparam logic [SUM_W-1:0] S_MAX = SUM_W'(ss_sym_max(SS_W));

    logic             round_up;
    logic [SUM_W-1:0] sum;

    // Round up when the fractional part strictly exceeds the random number, then clamp.
    always_comb begin
        round_up = (x[RAND_W-1:0] > rnd);
        sum      = SUM_W'(x[IN_W-1:RAND_W]) + SUM_W'(round_up);
        s        = (sum > S_MAX) ? S_MAX[SS_W-1:0] : sum[SS_W-1:0];
    end

endmodule

// File: rtl/ss_mac_seq.sv
// Sequenced stochastic-symbol MAC. A start in IDLE latches the run setup and
// accumulates one channel's symbol per cycle for len cycles, then pulses done.
// Optional build macro SS_MAC_SAT_EN: accumulator clamps at all-ones on
// overflow instead of wrapping (ovf is sticky either way).
module ss_mac_seq
    import ss_mac_pkg::*;
#(
    parameter int N_CH   = SS_DEF_N_CH,
    parameter int IN_W   = SS_DEF_IN_W,
    parameter int RAND_W = SS_DEF_RAND_W,
    parameter int SS_W   = SS_DEF_SS_W,
    parameter int LEN_W  = SS_DEF_LEN_W,
    parameter int ACC_W  = SS_DEF_ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    ss_mac_seq_if.slave  bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [SS_W-1:0] sym [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_sym
            ss_symbol_gen #(
                .IN_W   (IN_W),
                .RAND_W (RAND_W),
                .SS_W   (SS_W)
            ) u_sym (
                .x   (bus.x_input[gi*IN_W +: IN_W]),
                .rnd (bus.x_randnum[gi*RAND_W +: RAND_W]),
                .s   (sym[gi])
            );
        end
    endgenerate

    ss_state_e        state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg,   cnt_next;
    logic             mode_reg,  mode_next;
    logic [SEL_W-1:0] ch_reg,    ch_next;
    logic [ACC_W-1:0] acc_reg,   acc_next;
    logic             ovf_reg,   ovf_next;
    logic             busy_next_out, done_next_out;
    logic [SEL_W-1:0] sel_clamped;
    logic [ACC_W:0]   acc_sum;

    // Out-of-range start channels collapse onto the last channel.
    always_comb begin
        sel_clamped = (32'(bus.sel) > N_CH - 1) ? LAST_CH : bus.sel;
    end

    // State and datapath registers; reset returns everything to zero immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
            ch_reg    <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            ch_reg    <= ch_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state, accumulate and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mode_next     = mode_reg;
        ch_next       = ch_reg;
        acc_next      = acc_reg;
        ovf_next      = ovf_reg;
        busy_next_out = 1'b0;
        done_next_out = 1'b0;
        acc_sum       = {1'b0, acc_reg} + (ACC_W+1)'(sym[ch_reg]);

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mode_next  = bus.mode;
                    ch_next    = sel_clamped;
                    cnt_next   = bus.len;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = (bus.len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy_next_out = 1'b1;
                if (acc_sum[ACC_W]) begin
                    ovf_next = 1'b1;
`ifdef SS_MAC_SAT_EN
                    acc_next = '1;
`else
                    acc_next = acc_sum[ACC_W-1:0];
`endif
                end else begin
                    acc_next = acc_sum[ACC_W-1:0];
                end
                cnt_next = cnt_reg - LEN_W'(1);
                if (mode_reg) begin
                    ch_next = (ch_reg == LAST_CH) ? '0 : ch_reg + SEL_W'(1);
                end
                if (cnt_reg == LEN_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_next_out = 1'b1;
                done_next_out = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_next_out;
    assign bus.done     = done_next_out;
    assign bus.z_output = acc_reg;
    assign bus.ovf      = ovf_reg;

endmodule

// File: tb/tb_ss_mac_seq.sv
// Scoreboard bench for ss_mac_seq: a default-width DUT and a 4-bit
// accumulator DUT run the same stimulus; expected results come from symbol
// arithmetic on the stimulus tables and are checked whenever done pulses.
module tb_ss_mac_seq;
    import ss_mac_pkg::*;

    localparam int N_CH    = 8;
    localparam int IN_W    = 9;
    localparam int RAND_W  = 8;
    localparam int SS_W    = 2;
    localparam int LEN_W   = 10;
    localparam int ACC_W   = 16;
    localparam int ACC_W_S = 4;
    localparam int SEL_W   = 3;

    typedef struct {
        int z;
        int ovf;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t exp_s_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ss_mac_seq_if #(.N_CH(N_CH), .IN_W(IN_W), .RAND_W(RAND_W), .SS_W(SS_W),
                    .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();
    ss_mac_seq_if #(.N_CH(N_CH), .IN_W(IN_W), .RAND_W(RAND_W), .SS_W(SS_W),
                    .LEN_W(LEN_W), .ACC_W(ACC_W_S)) bus_s ();

    assign bus_s.start     = bus.start;
    assign bus_s.len       = bus.len;
    assign bus_s.mode      = bus.mode;
    assign bus_s.sel       = bus.sel;
    assign bus_s.x_input   = bus.x_input;
    assign bus_s.x_randnum = bus.x_randnum;

    ss_mac_seq #(.N_CH(N_CH), .IN_W(IN_W), .RAND_W(RAND_W), .SS_W(SS_W),
                 .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ss_mac_seq #(.N_CH(N_CH), .IN_W(IN_W), .RAND_W(RAND_W), .SS_W(SS_W),
                 .LEN_W(LEN_W), .ACC_W(ACC_W_S)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Symbol value straight from the arithmetic definition.
    function automatic int ref_sym(input int x, input int r);
        int s;
        s = (x >> RAND_W) + (((x % (1 << RAND_W)) > r) ? 1 : 0);
        return (s > (1 << SS_W) - 1) ? (1 << SS_W) - 1 : s;
    endfunction

    task automatic gen(input int pat, output logic [N_CH*IN_W-1:0] xb,
                       output logic [N_CH*RAND_W-1:0] rb);
        int xi, ri;
        for (int c = 0; c < N_CH; c++) begin
            xi = int'($urandom_range(0, (1 << IN_W) - 1));
            ri = int'($urandom_range(0, (1 << RAND_W) - 1));
            case (pat)
                1: begin xi = 'h180; ri = 0; end
                2: begin
                    if (c % 3 == 0)      xi = 0;
                    else if (c % 3 == 1) xi = 'h100;
                    else begin xi = 'h180; ri = 0; end
                end
                4: begin
                    if (c == 0)      begin xi = 'h180; ri = 'h7F; end
                    else if (c == 1) begin xi = 'h180; ri = 'h80; end
                    else if (c == 2) xi = 0;
                end
                default: ;
            endcase
            xb[c*IN_W +: IN_W]     = IN_W'(xi);
            rb[c*RAND_W +: RAND_W] = RAND_W'(ri);
        end
    endtask

    task automatic run(input int len, input int mode, input int sel, input int pat,
                       input bit poke_run, input bit poke_done);
        logic [N_CH*IN_W-1:0]   xq[$];
        logic [N_CH*RAND_W-1:0] rq[$];
        logic [N_CH*IN_W-1:0]   xb;
        logic [N_CH*RAND_W-1:0] rb;
        int   ch, sum;
        exp_t e, es;
        ch  = (sel > N_CH - 1) ? N_CH - 1 : sel;
        sum = 0;
        for (int k = 0; k < len; k++) begin
            gen(pat, xb, rb);
            xq.push_back(xb);
            rq.push_back(rb);
            sum += ref_sym(int'(xb[ch*IN_W +: IN_W]), int'(rb[ch*RAND_W +: RAND_W]));
            if (mode != 0) ch = (ch + 1) % N_CH;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LEN_W'(len);
        bus.mode  = mode[0];
        bus.sel   = SEL_W'(sel);
        gen(0, xb, rb);
        bus.x_input   = xb;
        bus.x_randnum = rb;
        e.z    = sum;
        e.ovf  = 0;
        e.cyc  = cyc + 1 + len;
        es.cyc = e.cyc;
        es.ovf = (sum >= (1 << ACC_W_S)) ? 1 : 0;
`ifdef SS_MAC_SAT_EN
        es.z   = (sum >= (1 << ACC_W_S)) ? (1 << ACC_W_S) - 1 : sum;
`else
        es.z   = sum % (1 << ACC_W_S);
`endif
        exp_q.push_back(e);
        exp_s_q.push_back(es);
        @(negedge clk);
        for (int k = 0; k < len; k++) begin
            bus.start = 1'b0;
            if (poke_run && k == 1) begin
                bus.start = 1'b1;
                bus.len   = LEN_W'($urandom_range(1, 50));
                bus.sel   = SEL_W'($urandom_range(0, N_CH - 1));
                bus.mode  = ~bus.mode;
            end
            bus.x_input   = xq[k];
            bus.x_randnum = rq[k];
            @(negedge clk);
        end
        // DONE cycle: a start here must not be accepted.
        bus.start = poke_done;
        bus.len   = LEN_W'($urandom_range(1, 20));
        gen(0, xb, rb);
        bus.x_input   = xb;
        bus.x_randnum = rb;
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_busy", 32'(bus.busy), 0);
        chk("hold_z", 32'(bus.z_output), 32'(e.z));
        chk("hold_z_small", 32'(bus_s.z_output), 32'(es.z));
        chk("hold_ovf_small", 32'(bus_s.ovf), 32'(es.ovf));
    endtask

    task automatic run_reset();
        logic [N_CH*IN_W-1:0]   xb;
        logic [N_CH*RAND_W-1:0] rb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LEN_W'(8);
        bus.mode  = 1'b0;
        bus.sel   = SEL_W'(2);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gen(1, xb, rb);
            bus.x_input   = xb;
            bus.x_randnum = rb;
            @(negedge clk);
        end
        chk("pre_reset_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_z", 32'(bus.z_output), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_done", 32'(bus.done), 0);
        chk("rst_mid_ovf_small", 32'(bus_s.ovf), 0);
        chk("rst_mid_z_small", 32'(bus_s.z_output), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", 32'(bus.busy), 0);
        $display("txn reset-mid-run: outputs cleared");
    endtask

    // Monitor: whenever a DUT reports done, pop its expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("z_output", 32'(bus.z_output), 32'(e.z));
                    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    $display("txn acc16: z=%0d ovf=%0d cyc=%0d", bus.z_output, bus.ovf, cyc);
                end
            end
            if (rst && bus_s.done) begin
                if (exp_s_q.size() == 0) begin
                    chk("unexpected_done_small", 1, 0);
                end else begin
                    e = exp_s_q.pop_front();
                    chk("z_output_small", 32'(bus_s.z_output), 32'(e.z));
                    chk("ovf_small", 32'(bus_s.ovf), 32'(e.ovf));
                    chk("done_cycle_small", 32'(cyc), 32'(e.cyc));
                    $display("txn acc4: z=%0d ovf=%0d cyc=%0d", bus_s.z_output, bus_s.ovf, cyc);
                end
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.x_input   = '0;
        bus.x_randnum = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_z", 32'(bus.z_output), 0);
        chk("reset_ovf", 32'(bus.ovf), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_busy", 32'(bus.busy), 0);

        // Generator vectors through single-cycle fixed runs: 2, 1, 0.
        run(1, 0, 0, 4, 1'b0, 1'b0);
        run(1, 0, 1, 4, 1'b0, 1'b0);
        run(1, 0, 2, 4, 1'b0, 1'b0);
        // Fixed channel 3, symbol 2 for 10 cycles.
        run(10, 0, 3, 1, 1'b0, 1'b0);
        // Round-robin from channel 6 over symbols k mod 3.
        run(4, 1, 6, 2, 1'b0, 1'b0);
        // len = 0, then starts while busy and during DONE.
        run(0, 0, 5, 0, 1'b0, 1'b1);
        run(12, 0, 5, 0, 1'b1, 1'b1);
        // Overflow of the 4-bit accumulator: 9 x 2.
        run(9, 0, 4, 1, 1'b0, 1'b0);
        // Reset in the middle of a run, then a normal run.
        run_reset();
        run(5, 1, 7, 0, 1'b0, 1'b0);
        // Randomized runs.
        for (int i = 0; i < 25; i++) begin
            run(int'($urandom_range(0, 40)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, N_CH - 1)), 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);
        chk("pending_acc16", 32'(exp_q.size()), 0);
        chk("pending_acc4", 32'(exp_s_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
